inst_resp_buffer: RTL

//  Sits between custom_cpu instruction channels and instruction memory/bus port.

---
 rtl/inst_resp_buffer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/inst_resp_buffer.sv
// ---------------------------------------------------------------------------
// inst_resp_buffer
//
// Sits between the CPU instruction fetch channels and the instruction memory
// port. Fetch requests pass straight through to memory, but only while a
// credit is available: the number of requests still waiting for a response
// plus the number of buffered responses may never exceed DEPTH. Because every
// issued request is guaranteed a FIFO slot, the memory response channel is
// never back-pressured. Responses are returned to the CPU in request order
// from a small circular FIFO.
//
// Parameters
//   DEPTH  max outstanding + buffered fetches (power of 2, >= 2)
//   AW     address width
//   DW     instruction width
//
// Ports
//   clk                   clock, all state updates on rising edge
//   rst                   synchronous reset, active-high
//   PC                    fetch address from the CPU
//   Inst_Req_Valid        CPU fetch request valid
//   Inst_Req_Ready        fetch request accepted this cycle
//   Instruction           instruction at the FIFO head
//   Inst_Valid            Instruction is valid
//   Inst_Ready            CPU consumes Instruction
//   mem_inst_addr         request address to memory (equal to PC)
//   mem_inst_req_valid    memory request valid
//   mem_inst_req_ready    memory accepts the request
//   mem_inst_rdata        memory response data
//   mem_inst_rdata_valid  memory response valid
//   mem_inst_rdata_ready  buffer accepts the response (high outside reset)
//   inflight_cnt          requests issued whose response has not arrived
//   protocol_err          sticky: a response arrived with nothing in flight
// ---------------------------------------------------------------------------
module inst_resp_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AW-1:0]              PC,
    input  logic                       Inst_Req_Valid,
    output logic                       Inst_Req_Ready,
    output logic [DW-1:0]              Instruction,
    output logic                       Inst_Valid,
    input  logic                       Inst_Ready,
    output logic [AW-1:0]              mem_inst_addr,
    output logic                       mem_inst_req_valid,
    input  logic                       mem_inst_req_ready,
    input  logic [DW-1:0]              mem_inst_rdata,
    input  logic                       mem_inst_rdata_valid,
    output logic                       mem_inst_rdata_ready,
    output logic [$clog2(DEPTH):0]     inflight_cnt,
    output logic                       protocol_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_LIMIT = (CW+1)'(DEPTH);

    logic [CW-1:0] r_inflightCnt;
    logic [CW-1:0] r_fifoCount;
    logic [PW-1:0] r_rdPtr;
    logic [PW-1:0] r_wrPtr;
    logic [DW-1:0] r_fifoMem [DEPTH];
    logic          r_protocolErr;

    logic [CW:0]   w_creditSum;
    logic          w_creditOk;
    logic          w_reqFire;
    logic          w_respFire;
    logic          w_inflightNz;
    logic          w_push;
    logic          w_pop;

    // Credit accounting uses one extra bit so that inflight + buffered can be
    // compared against DEPTH without wrapping. A request may only be issued
    // when it is certain to find a FIFO slot for its response.
    always_comb begin
        w_creditSum  = {1'b0, r_inflightCnt} + {1'b0, r_fifoCount};
        w_creditOk   = (w_creditSum < DEPTH_LIMIT);
        w_inflightNz = (r_inflightCnt != '0);
    end

    // Request path is a pure pass-through gated by credit and reset; the
    // handshake itself happens in the memory, we only decide whether the CPU
    // is allowed to see it.
    always_comb begin
        mem_inst_addr        = PC;
        mem_inst_req_valid   = Inst_Req_Valid & w_creditOk & ~rst;
        Inst_Req_Ready       = mem_inst_req_ready & w_creditOk & ~rst;
        mem_inst_rdata_ready = ~rst;
    end

    // A response with nothing in flight is not written: it cannot belong to
    // any request we forwarded, so it only raises the sticky error flag.
    always_comb begin
        w_reqFire  = Inst_Req_Valid & Inst_Req_Ready;
        w_respFire = mem_inst_rdata_valid & ~rst;
        w_push     = w_respFire & w_inflightNz;
        w_pop      = Inst_Valid & Inst_Ready;
    end

    // CPU side reads the head of the FIFO directly from registered state, so
    // a response never bypasses the buffer and appears one cycle after it
    // was written. The head stays put until it is popped.
    always_comb begin
        Inst_Valid   = (r_fifoCount != '0);
        Instruction  = r_fifoMem[r_rdPtr];
        inflight_cnt = r_inflightCnt;
        protocol_err = r_protocolErr;
    end

    // Outstanding request counter. A request and a matching response in the
    // same cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflightCnt <= '0;
        end else begin
            case ({w_reqFire, w_push})
                2'b10:   r_inflightCnt <= r_inflightCnt + 1'b1;
                2'b01:   r_inflightCnt <= r_inflightCnt - 1'b1;
                default: r_inflightCnt <= r_inflightCnt;
            endcase
        end
    end

    // FIFO pointers and occupancy. DEPTH is a power of two, so the pointers
    // wrap naturally. A simultaneous push and pop moves both pointers and
    // leaves the occupancy unchanged, which also holds when the FIFO is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdPtr     <= '0;
            r_wrPtr     <= '0;
            r_fifoCount <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifoCount <= r_fifoCount + 1'b1;
                2'b01:   r_fifoCount <= r_fifoCount - 1'b1;
                default: r_fifoCount <= r_fifoCount;
            endcase
        end
    end

    // Storage array carries no reset; its contents are only observable
    // through entries that the occupancy count marks as valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoMem[r_wrPtr] <= mem_inst_rdata;
        end
    end

    // Sticky protocol error, cleared only by reset. A memory that is not
    // reset together with this block will trip it with its late responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_protocolErr <= 1'b0;
        end else if (w_respFire & ~w_inflightNz) begin
            r_protocolErr <= 1'b1;
        end
    end

endmodule
